id_stage: RTL and testbench

Instruction-decode pipeline register for the RISC-Z core, sitting directly upstream of `mov_ext`. It captures a fetched 16-bit instruction and its PC on each accepted cycle and decodes it into registered fields and control strobes. It supports stall (hold) and flush (bubble) from the hazard/branch logic. `MovOp`/`MovIn` drive `mov_ext` directly, and a one-deep load-use hazard detector requests stalls from fetch.

---
 rtl/id_stage.sv | 169 ++++++++++++++++
 tb/tb_id_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage -- instruction-decode pipeline register for the RISC-Z core.
//
// Captures a fetched 16-bit instruction and its PC on every accepted cycle
// and presents registered instruction fields plus decoded control strobes.
// MovOp/MovIn feed mov_ext directly. A one-deep load-use detector raises
// HazardStall (combinational) toward fetch for exactly one cycle per
// load-use pair.
//
// Optional feature macro: ID_ILLEGAL_TRAP_EN
//   defined   : illegal opcodes (>= ILLEGAL_BASE) load a bubble and set the
//               sticky IllegalFlag output.
//   undefined : illegal opcodes load as valid NOPs; no IllegalFlag port.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   InstrIn, PcIn      fetched instruction and its PC
//   InstrValid         InstrIn/PcIn valid this cycle
//   Stall, Flush       hold / bubble requests from hazard and branch logic
//   ValidOut, PcOut    stage holds a real instruction, registered PC
//   Opcode/Rd/Rs/Rt    raw instruction fields [15:12]/[11:8]/[7:4]/[3:0]
//   MovIn, MovOp       low byte and sign-extend select for mov_ext
//   RegWrite, MemRead, MemWrite, Branch, Jump   control strobes
//   HazardStall        load-use stall request to fetch
//   IllegalFlag        sticky illegal-opcode flag (macro builds only)
module id_stage #(
    parameter logic [3:0] ILLEGAL_BASE = 4'hB
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] InstrIn,
    input  logic [15:0] PcIn,
    input  logic        InstrValid,
    input  logic        Stall,
    input  logic        Flush,
    output logic        ValidOut,
    output logic [15:0] PcOut,
    output logic [3:0]  Opcode,
    output logic [3:0]  Rd,
    output logic [3:0]  Rs,
    output logic [3:0]  Rt,
    output logic [7:0]  MovIn,
    output logic        MovOp,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
`ifdef ID_ILLEGAL_TRAP_EN
    output logic        IllegalFlag,
`endif
    output logic        HazardStall
);

    // Control word layout: {reg_write, mem_read, mem_write, branch, jump, mov_op}
    function automatic logic [5:0] decode_ctrl(input logic [3:0] op);
        logic [5:0] c;
        c = 6'b000000;
        if (op < ILLEGAL_BASE) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: c = 6'b100000;
                4'h5:                   c = 6'b100000;
                4'h6:                   c = 6'b100001;
                4'h7:                   c = 6'b110000;
                4'h8:                   c = 6'b001000;
                4'h9:                   c = 6'b000100;
                4'hA:                   c = 6'b000010;
                default:                c = 6'b000000;
            endcase
        end
        return c;
    endfunction

    // Opcodes whose Rs/Rt fields are genuine register reads.
    function automatic logic reads_src(input logic [3:0] op);
        logic r;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'h9: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    logic        vld_p1;
    logic [15:0] pc_p1;
    logic [15:0] instr_p1;
    logic [5:0]  ctrl_p1;
    // Set after the single load-use stall cycle so the held LD is released
    // on the next edge instead of re-triggering the same hazard forever.
    logic        hz_done_p1;

    logic [3:0]  in_op;
    logic        in_illegal;
    logic        trap_illegal;
    logic        load_vld;
    logic [5:0]  dec_ctrl;
    logic        hz_raw;
    logic        hold;

    assign in_op      = InstrIn[15:12];
    assign in_illegal = (in_op >= ILLEGAL_BASE);
    assign dec_ctrl   = decode_ctrl(in_op);

`ifdef ID_ILLEGAL_TRAP_EN
    assign trap_illegal = in_illegal;
`else
    assign trap_illegal = 1'b0;
`endif

    assign load_vld = InstrValid & ~trap_illegal;

    assign hz_raw = vld_p1 & ctrl_p1[4] & InstrValid & reads_src(in_op) &
                    ((instr_p1[11:8] == InstrIn[7:4]) | (instr_p1[11:8] == InstrIn[3:0]));

    assign HazardStall = hz_raw & ~hz_done_p1 & ~Flush;
    assign hold        = Stall | HazardStall;

    // ---- stage p0 -> p1 boundary ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            instr_p1   <= '0;
            ctrl_p1    <= '0;
            hz_done_p1 <= 1'b0;
        end else if (Flush) begin
            vld_p1     <= 1'b0;
            instr_p1   <= '0;
            ctrl_p1    <= '0;
            hz_done_p1 <= 1'b0;
        end else if (hold) begin
            hz_done_p1 <= hz_done_p1 | HazardStall;
        end else begin
            vld_p1     <= load_vld;
            pc_p1      <= PcIn;
            instr_p1   <= load_vld ? InstrIn : 16'h0000;
            ctrl_p1    <= load_vld ? dec_ctrl : 6'b000000;
            hz_done_p1 <= 1'b0;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic ill_p1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ill_p1 <= 1'b0;
        end else if (!Flush && !hold && InstrValid && in_illegal) begin
            ill_p1 <= 1'b1;
        end
    end

    assign IllegalFlag = ill_p1;
`endif

    assign ValidOut = vld_p1;
    assign PcOut    = pc_p1;
    assign Opcode   = instr_p1[15:12];
    assign Rd       = instr_p1[11:8];
    assign Rs       = instr_p1[7:4];
    assign Rt       = instr_p1[3:0];
    assign MovIn    = instr_p1[7:0];
    assign RegWrite = ctrl_p1[5];
    assign MemRead  = ctrl_p1[4];
    assign MemWrite = ctrl_p1[3];
    assign Branch   = ctrl_p1[2];
    assign Jump     = ctrl_p1[1];
    assign MovOp    = ctrl_p1[0];

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with a scoreboard of expected stage
// contents. Works with and without ID_ILLEGAL_TRAP_EN defined.
module tb_id_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] InstrIn = '0;
    logic [15:0] PcIn = '0;
    logic        InstrValid = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        ValidOut;
    logic [15:0] PcOut;
    logic [3:0]  Opcode, Rd, Rs, Rt;
    logic [7:0]  MovIn;
    logic        MovOp, RegWrite, MemRead, MemWrite, Branch, Jump, HazardStall;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        IllegalFlag;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 Clk = ~Clk;

    id_stage dut (
        .Clk(Clk), .Reset(Reset), .InstrIn(InstrIn), .PcIn(PcIn),
        .InstrValid(InstrValid), .Stall(Stall), .Flush(Flush),
        .ValidOut(ValidOut), .PcOut(PcOut), .Opcode(Opcode), .Rd(Rd),
        .Rs(Rs), .Rt(Rt), .MovIn(MovIn), .MovOp(MovOp), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
`ifdef ID_ILLEGAL_TRAP_EN
        .IllegalFlag(IllegalFlag),
`endif
        .HazardStall(HazardStall)
    );

    typedef struct packed {
        logic        vld;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [7:0]  movin;
        logic [5:0]  ctrl;   // {RegWrite, MemRead, MemWrite, Branch, Jump, MovOp}
        logic        ill;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Bench-side view of the stage contents.
    logic        m_vld = 0;
    logic [15:0] m_pc = 0;
    logic [15:0] m_instr = 0;
    logic [5:0]  m_ctrl = 0;
    logic        m_ill = 0;

    function automatic logic [5:0] ref_ctrl(input logic [3:0] op);
        logic [5:0] tbl [16];
        tbl = '{6'b000000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                6'b100000, 6'b100001, 6'b110000, 6'b001000, 6'b000100,
                6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                6'b000000};
        return tbl[op];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic out_t observe();
        out_t o;
        o.vld   = ValidOut;
        o.pc    = PcOut;
        o.instr = {Opcode, Rd, Rs, Rt};
        o.movin = MovIn;
        o.ctrl  = {RegWrite, MemRead, MemWrite, Branch, Jump, MovOp};
`ifdef ID_ILLEGAL_TRAP_EN
        o.ill   = IllegalFlag;
`else
        o.ill   = 1'b0;
`endif
        return o;
    endfunction

    // One clock: drive inputs at negedge, check HazardStall, push expected
    // stage contents, compare after the rising edge.
    task automatic step(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                        input logic iv, input logic st, input logic fl, input logic rs,
                        input logic exp_hz);
        out_t e;
        out_t got;
        logic illegal;
        @(negedge Clk);
        InstrIn = instr; PcIn = pc; InstrValid = iv; Stall = st; Flush = fl; Reset = rs;
        #1;
        check({tag, "/hz"}, {63'd0, HazardStall}, {63'd0, exp_hz});
        illegal = (instr[15:12] >= 4'hB);
        if (rs) begin
            m_vld = 0; m_pc = 0; m_instr = 0; m_ctrl = 0; m_ill = 0;
        end else if (fl) begin
            m_vld = 0; m_instr = 0; m_ctrl = 0;
        end else if (!(st || exp_hz)) begin
            m_pc = pc;
            if (iv && !(TRAP && illegal)) begin
                m_vld = 1; m_instr = instr; m_ctrl = ref_ctrl(instr[15:12]);
            end else begin
                m_vld = 0; m_instr = 0; m_ctrl = 0;
            end
            if (iv && illegal && TRAP) m_ill = 1;
        end
        e.vld = m_vld; e.pc = m_pc; e.instr = m_instr; e.movin = m_instr[7:0];
        e.ctrl = m_ctrl; e.ill = m_ill;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        got = observe();
        e = exp_q.pop_front();
        check(tag, {17'd0, got}, {17'd0, e});
    endtask

    initial begin
        // Reset state
        step("reset", 16'h0000, 16'h0000, 0, 0, 0, 1, 0);
        check("reset_vld", {63'd0, ValidOut}, 64'd0);
        check("reset_pc", {48'd0, PcOut}, 64'd0);

        // MOVZ R3,0xFF
        step("movz", 16'h53FF, 16'h0010, 1, 0, 0, 0, 0);
        check("movz_rd", {60'd0, Rd}, 64'd3);
        check("movz_movin", {56'd0, MovIn}, 64'hFF);
        check("movz_ctl", {62'd0, MovOp, RegWrite}, 64'b01);

        // MOVS then ADD back-to-back
        step("movs", 16'h6201, 16'h0012, 1, 0, 0, 0, 0);
        check("movs_op", {59'd0, Opcode, MovOp}, {59'd0, 4'h6, 1'b1});
        step("add", 16'h1123, 16'h0014, 1, 0, 0, 0, 0);
        check("add_op", {59'd0, Opcode, MovOp}, {59'd0, 4'h1, 1'b0});

        // Load-use via Rs: one stall cycle, LD held, ADD a cycle later
        step("ld4", 16'h7400, 16'h0016, 1, 0, 0, 0, 0);
        step("ld4_hold", 16'h1540, 16'h0018, 1, 0, 0, 0, 1);
        check("ld4_held", {48'd0, Opcode, PcOut[11:0]}, {48'd0, 4'h7, 12'h016});
        step("add_after_ld", 16'h1540, 16'h0018, 1, 0, 0, 0, 0);
        check("add_after_ld_rd", {60'd0, Rd}, 64'd5);

        // Stall 3 cycles with flush in cycle 2
        step("sub", 16'h2345, 16'h0020, 1, 0, 0, 0, 0);
        step("stall1", 16'hA000, 16'h0022, 1, 1, 0, 0, 0);
        check("stall1_hold", {47'd0, ValidOut, PcOut}, {47'd0, 1'b1, 16'h0020});
        step("stall2_flush", 16'hA000, 16'h0022, 1, 1, 1, 0, 0);
        check("flush_bubble", {47'd0, ValidOut, PcOut}, {47'd0, 1'b0, 16'h0020});
        step("stall3", 16'hA000, 16'h0022, 1, 1, 0, 0, 0);

        // Remaining opcode classes
        step("jmp", 16'hA000, 16'h0022, 1, 0, 0, 0, 0);
        step("st", 16'h8123, 16'h0024, 1, 0, 0, 0, 0);
        step("beq", 16'h9456, 16'h0026, 1, 0, 0, 0, 0);

        // Illegal opcode
        step("illegal", 16'hC000, 16'h0028, 1, 0, 0, 0, 0);
`ifdef ID_ILLEGAL_TRAP_EN
        check("illegal_trap", {62'd0, ValidOut, IllegalFlag}, 64'b01);
`else
        check("illegal_nop", {57'd0, ValidOut, RegWrite, MemRead, MemWrite, Branch, Jump, MovOp}, 64'b1000000);
`endif
        step("nop", 16'h0000, 16'h002A, 1, 0, 0, 0, 0);
        step("invalid_in", 16'h1234, 16'h002C, 0, 0, 0, 0, 0);

        // Flush masks a load-use hazard
        step("ld3a", 16'h7300, 16'h0030, 1, 0, 0, 0, 0);
        step("flush_mask", 16'h1030, 16'h0032, 1, 0, 1, 0, 0);
        // Hazard via Rt match
        step("ld3b", 16'h7300, 16'h0034, 1, 0, 0, 0, 0);
        step("rt_hold", 16'h2013, 16'h0036, 1, 0, 0, 0, 1);
        step("rt_go", 16'h2013, 16'h0036, 1, 0, 0, 0, 0);
        // JMP does not read registers: no hazard
        step("ld3c", 16'h7300, 16'h0038, 1, 0, 0, 0, 0);
        step("jmp_nohz", 16'hA033, 16'h003A, 1, 0, 0, 0, 0);

        // Reset while an LD is held with HazardStall active
        step("ld4r", 16'h7400, 16'h0040, 1, 0, 0, 0, 0);
        step("reset_in_hz", 16'h1540, 16'h0042, 1, 0, 0, 1, 1);
        check("reset_in_hz_zero", {47'd0, ValidOut, PcOut}, 64'd0);
        step("after_reset", 16'h1540, 16'h0042, 1, 0, 0, 0, 0);
        check("after_reset_vld", {63'd0, ValidOut}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
